// File: rtl/tlb_multilevel.sv
// Fully associative multi-level TLB: combinational lookup with superpage support,
// tree-PLRU refill replacement and a sequential one-entry-per-cycle flush engine.
module tlb_multilevel #(
    parameter int TLB_ENTRIES  = 8,
    parameter int ASID_WIDTH   = 9,
    parameter int LEVELS       = 2,
    parameter int VPN_W        = 10,
    parameter int CONTENT_W    = 32,
    localparam int VA_W        = 12 + LEVELS*VPN_W,
    localparam int SZ_W        = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          lu_access_i,
    input  logic [ASID_WIDTH-1:0]         lu_asid_i,
    input  logic [VA_W-1:0]               lu_vaddr_i,
    output logic                          lu_hit_o,
    output logic [CONTENT_W-1:0]          lu_content_o,
    output logic [SZ_W-1:0]               lu_size_o,
    input  logic                          upd_valid_i,
    output logic                          upd_ready_o,
    input  logic [LEVELS*VPN_W-1:0]       upd_vpn_i,
    input  logic [ASID_WIDTH-1:0]         upd_asid_i,
    input  logic [SZ_W-1:0]               upd_size_i,
    input  logic                          upd_global_i,
    input  logic [CONTENT_W-1:0]          upd_content_i,
    input  logic                          flush_req_i,
    input  logic [ASID_WIDTH-1:0]         flush_asid_i,
    input  logic [VA_W-1:0]               flush_vaddr_i,
    output logic                          flush_busy_o,
    output logic                          flush_done_o,
    output logic [$clog2(TLB_ENTRIES):0]  valid_count_o
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    localparam int VPN_T = LEVELS*VPN_W;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_e;

    // Handshake: a refill transfers on a cycle where upd_valid_i & upd_ready_o are both high.

    logic [TLB_ENTRIES-1:0] valid_q, valid_d;
    logic [TLB_ENTRIES-1:0] global_q;
    logic [ASID_WIDTH-1:0]  asid_q    [TLB_ENTRIES];
    logic [VPN_T-1:0]       vpn_q     [TLB_ENTRIES];
    logic [SZ_W-1:0]        size_q    [TLB_ENTRIES];
    logic [CONTENT_W-1:0]   content_q [TLB_ENTRIES];
    logic [TLB_ENTRIES-2:0] plru_q, plru_d;
    logic [IDX_W:0]         count_q;
    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [ASID_WIDTH-1:0]  fasid_q, fasid_d;
    logic [VA_W-1:0]        fva_q, fva_d;

    // Levels below the entry's page size are offset bits and never compared.
    function automatic logic vpn_match(input logic [VPN_T-1:0] e_vpn,
                                       input logic [SZ_W-1:0] sz,
                                       input logic [VA_W-1:0] va);
        logic m;
        m = 1'b1;
        for (int k = 0; k < LEVELS; k++) begin
            if (k >= int'(sz) && e_vpn[k*VPN_W +: VPN_W] != va[12 + k*VPN_W +: VPN_W]) m = 1'b0;
        end
        return m;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic logic [TLB_ENTRIES-2:0] plru_touch(input logic [TLB_ENTRIES-2:0] t,
                                                          input logic [IDX_W-1:0] idx);
        logic [TLB_ENTRIES-2:0] r;
        logic [IDX_W-1:0]       node;
        logic                   b;
        r    = t;
        node = '0;
        for (int l = 0; l < IDX_W; l++) begin
            b       = idx[IDX_W-1-l];
            r[node] = ~b;
            node    = IDX_W'(2*int'(node) + 1 + int'(b));
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] plru_victim(input logic [TLB_ENTRIES-2:0] t);
        logic [IDX_W-1:0] v;
        logic [IDX_W-1:0] node;
        logic             b;
        v    = '0;
        node = '0;
        for (int l = 0; l < IDX_W; l++) begin
            b             = t[node];
            v[IDX_W-1-l]  = b;
            node          = IDX_W'(2*int'(node) + 1 + int'(b));
        end
        return v;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [TLB_ENTRIES-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) c = c + {{IDX_W{1'b0}}, v[i]};
        return c;
    endfunction

    // Lookup: descending scan so the lowest matching index wins.
    logic             lu_match;
    logic [IDX_W-1:0] lu_idx;
    always_comb begin
        lu_match = 1'b0;
        lu_idx   = '0;
        for (int i = TLB_ENTRIES-1; i >= 0; i--) begin
            if (valid_q[i] && (global_q[i] || asid_q[i] == lu_asid_i) &&
                vpn_match(vpn_q[i], size_q[i], lu_vaddr_i)) begin
                lu_match = 1'b1;
                lu_idx   = IDX_W'(i);
            end
        end
    end

    assign flush_busy_o  = (state_q != S_IDLE);
    assign flush_done_o  = (state_q == S_DONE);
    assign lu_hit_o      = lu_match & ~flush_busy_o;
    assign lu_content_o  = lu_hit_o ? content_q[lu_idx] : '0;
    assign lu_size_o     = lu_hit_o ? size_q[lu_idx] : '0;
    assign upd_ready_o   = (state_q == S_IDLE) & ~flush_req_i;
    assign valid_count_o = count_q;

    // Refill target: duplicate overwrite, then lowest free slot, then PLRU victim.
    logic             upd_acc;
    logic             dup_hit, free_hit;
    logic [IDX_W-1:0] dup_idx, free_idx, tgt_idx;
    always_comb begin
        dup_hit  = 1'b0;
        dup_idx  = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = TLB_ENTRIES-1; i >= 0; i--) begin
            if (valid_q[i] && vpn_q[i] == upd_vpn_i && asid_q[i] == upd_asid_i &&
                size_q[i] == upd_size_i) begin
                dup_hit = 1'b1;
                dup_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        tgt_idx = dup_hit ? dup_idx : (free_hit ? free_idx : plru_victim(plru_q));
        upd_acc = upd_valid_i & upd_ready_o;
    end

    // Flush criterion for the entry currently under the counter; zero fields are wildcards.
    logic flush_hit;
    always_comb begin
        logic any_asid, any_va, addr_ok, asid_ok;
        any_asid  = (fasid_q == '0);
        any_va    = (fva_q == '0);
        addr_ok   = vpn_match(vpn_q[cnt_q], size_q[cnt_q], fva_q);
        asid_ok   = (asid_q[cnt_q] == fasid_q) && !global_q[cnt_q];
        flush_hit = valid_q[cnt_q] && (any_asid || asid_ok) && (any_va || addr_ok);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fasid_d = fasid_q;
        fva_d   = fva_q;
        valid_d = valid_q;
        plru_d  = plru_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_req_i) begin
                    fasid_d = flush_asid_i;
                    fva_d   = flush_vaddr_i;
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_hit) valid_d[cnt_q] = 1'b0;
                if (cnt_q == IDX_W'(TLB_ENTRIES-1)) state_d = S_DONE;
                else                                cnt_d   = cnt_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (upd_acc) valid_d[tgt_idx] = 1'b1;
        // Refill touch is applied after the lookup touch so it dominates.
        if (lu_access_i && lu_hit_o) plru_d = plru_touch(plru_d, lu_idx);
        if (upd_acc)                 plru_d = plru_touch(plru_d, tgt_idx);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fasid_q <= '0;
            fva_q   <= '0;
            valid_q <= '0;
            plru_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fasid_q <= fasid_d;
            fva_q   <= fva_d;
            valid_q <= valid_d;
            plru_q  <= plru_d;
            count_q <= popcount(valid_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (upd_acc) begin
            asid_q[tgt_idx]    <= upd_asid_i;
            vpn_q[tgt_idx]     <= upd_vpn_i;
            size_q[tgt_idx]    <= upd_size_i;
            global_q[tgt_idx]  <= upd_global_i;
            content_q[tgt_idx] <= upd_content_i;
        end
    end

endmodule

// File: tb/tb_tlb_multilevel.sv
// Directed bench for tlb_multilevel: fill, superpage, PLRU victim, duplicate
// overwrite, flush variants, refill/flush collision and reset during flush.
module tb_tlb_multilevel;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lu_access_i;
    logic [8:0]  lu_asid_i;
    logic [31:0] lu_vaddr_i;
    logic        lu_hit_o;
    logic [31:0] lu_content_o;
    logic [1:0]  lu_size_o;
    logic        upd_valid_i;
    logic        upd_ready_o;
    logic [19:0] upd_vpn_i;
    logic [8:0]  upd_asid_i;
    logic [1:0]  upd_size_i;
    logic        upd_global_i;
    logic [31:0] upd_content_i;
    logic        flush_req_i;
    logic [8:0]  flush_asid_i;
    logic [31:0] flush_vaddr_i;
    logic        flush_busy_o;
    logic        flush_done_o;
    logic [3:0]  valid_count_o;

    int checks = 0;
    int errors = 0;

    tlb_multilevel dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lu_access_i(lu_access_i), .lu_asid_i(lu_asid_i), .lu_vaddr_i(lu_vaddr_i),
        .lu_hit_o(lu_hit_o), .lu_content_o(lu_content_o), .lu_size_o(lu_size_o),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_vpn_i(upd_vpn_i),
        .upd_asid_i(upd_asid_i), .upd_size_i(upd_size_i), .upd_global_i(upd_global_i),
        .upd_content_i(upd_content_i),
        .flush_req_i(flush_req_i), .flush_asid_i(flush_asid_i), .flush_vaddr_i(flush_vaddr_i),
        .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
        .valid_count_o(valid_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [8:0]  asid;
        logic [31:0] va;
        logic        hit;
        logic [31:0] content;
        logic [1:0]  size;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic lookup_check(input string name, input logic [8:0] asid, input logic [31:0] va,
                                input logic hit, input logic [31:0] content, input logic [1:0] size);
        lu_asid_i  = asid;
        lu_vaddr_i = va;
        #1;
        check({name, "_hit"}, lu_hit_o, hit);
        check({name, "_content"}, lu_content_o, content);
        check({name, "_size"}, lu_size_o, size);
    endtask

    task automatic touch(input logic [31:0] va);
        lu_asid_i   = 9'd1;
        lu_vaddr_i  = va;
        lu_access_i = 1'b1;
        #1;
        check("touch_hit", lu_hit_o, 1'b1);
        @(posedge clk_i); #1;
        lu_access_i = 1'b0;
    endtask

    task automatic refill(input logic [19:0] vpn, input logic [8:0] asid, input logic [1:0] size,
                          input logic glb, input logic [31:0] content);
        upd_vpn_i     = vpn;
        upd_asid_i    = asid;
        upd_size_i    = size;
        upd_global_i  = glb;
        upd_content_i = content;
        upd_valid_i   = 1'b1;
        #1;
        check("refill_ready", upd_ready_o, 1'b1);
        @(posedge clk_i); #1;
        upd_valid_i = 1'b0;
    endtask

    task automatic start_flush(input logic [8:0] asid, input logic [31:0] va);
        flush_asid_i  = asid;
        flush_vaddr_i = va;
        flush_req_i   = 1'b1;
        @(posedge clk_i); #1;
        flush_req_i = 1'b0;
    endtask

    // Returns in the cycle where flush_done_o is observed high.
    task automatic wait_done(input string name, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(posedge clk_i); #1;
            if (flush_done_o) seen = 1'b1;
        end
        check(name, seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen_done;
        rst_ni = 1'b0;
        lu_access_i = 0; lu_asid_i = 0; lu_vaddr_i = 0;
        upd_valid_i = 0; upd_vpn_i = 0; upd_asid_i = 0; upd_size_i = 0;
        upd_global_i = 0; upd_content_i = 0;
        flush_req_i = 0; flush_asid_i = 0; flush_vaddr_i = 0;

        // Reset values.
        #3;
        check("rst_hit", lu_hit_o, 1'b0);
        check("rst_count", valid_count_o, 4'd0);
        check("rst_busy", flush_busy_o, 1'b0);
        check("rst_done", flush_done_o, 1'b0);
        check("rst_ready", upd_ready_o, 1'b1);
        flush_req_i = 1'b1;
        #1;
        check("rst_ready_flushreq", upd_ready_o, 1'b0);
        flush_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_busy", flush_busy_o, 1'b0);

        // Fill 8 entries, asid 1, vpn 0..7.
        for (int i = 0; i < 8; i++) refill(20'(i), 9'd1, 2'd0, 1'b0, 32'hC000_0000 + 32'(i));
        @(posedge clk_i); #1;
        check("fill_count", valid_count_o, 4'd8);
        lookup_check("fill_3000", 9'd1, 32'h0000_3000, 1'b1, 32'hC000_0003, 2'd0);
        lookup_check("fill_asid2", 9'd2, 32'h0000_3000, 1'b0, 32'h0, 2'd0);

        // Touch order leaves the tree pointing at entry 7: root->upper, 4..7->6/7, 6/7->7.
        touch(32'h6000); touch(32'h4000); touch(32'h5000);
        touch(32'h0000); touch(32'h1000); touch(32'h2000); touch(32'h3000);
        refill({10'd5, 10'd0}, 9'd3, 2'd1, 1'b1, 32'h5555_0001);
        // Duplicate of entry 2 must overwrite in place.
        refill(20'd2, 9'd1, 2'd0, 1'b0, 32'hDEAD_0002);
        @(posedge clk_i); #1;
        check("full_count", valid_count_o, 4'd8);

        vecs[0]  = '{9'd1,   32'h0000_0000, 1'b1, 32'hC000_0000, 2'd0};
        vecs[1]  = '{9'd1,   32'h0000_1ABC, 1'b1, 32'hC000_0001, 2'd0};
        vecs[2]  = '{9'd1,   32'h0000_2000, 1'b1, 32'hDEAD_0002, 2'd0};
        vecs[3]  = '{9'd1,   32'h0000_3000, 1'b1, 32'hC000_0003, 2'd0};
        vecs[4]  = '{9'd1,   32'h0000_4FFF, 1'b1, 32'hC000_0004, 2'd0};
        vecs[5]  = '{9'd1,   32'h0000_5000, 1'b1, 32'hC000_0005, 2'd0};
        vecs[6]  = '{9'd1,   32'h0000_6000, 1'b1, 32'hC000_0006, 2'd0};
        vecs[7]  = '{9'd1,   32'h0000_7000, 1'b0, 32'h0,         2'd0};
        vecs[8]  = '{9'd2,   32'h0000_3000, 1'b0, 32'h0,         2'd0};
        vecs[9]  = '{9'd3,   32'h0152_3000, 1'b1, 32'h5555_0001, 2'd1};
        vecs[10] = '{9'h1FF, 32'h017F_F000, 1'b1, 32'h5555_0001, 2'd1};
        vecs[11] = '{9'd3,   32'h0100_0000, 1'b0, 32'h0,         2'd0};
        vecs[12] = '{9'd1,   32'h0140_0000, 1'b1, 32'h5555_0001, 2'd1};
        vecs[13] = '{9'd1,   32'h0040_0000, 1'b0, 32'h0,         2'd0};
        for (int i = 0; i < 14; i++)
            lookup_check($sformatf("vec%0d", i), vecs[i].asid, vecs[i].va,
                         vecs[i].hit, vecs[i].content, vecs[i].size);

        // Flush asid 1 colliding with a refill: flush wins, refill dropped.
        flush_asid_i = 9'd1; flush_vaddr_i = 32'h0; flush_req_i = 1'b1;
        upd_valid_i = 1'b1; upd_vpn_i = 20'd9; upd_asid_i = 9'd5; upd_size_i = 2'd0;
        upd_global_i = 1'b0; upd_content_i = 32'hBAD0_0009;
        #1;
        check("race_ready", upd_ready_o, 1'b0);
        @(posedge clk_i); #1;
        flush_req_i = 1'b0; upd_valid_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 1) begin
                lu_asid_i = 9'd1; lu_vaddr_i = 32'h0000_3000;
                #1;
                check("busy_lookup_hit", lu_hit_o, 1'b0);
                check("busy_lookup_content", lu_content_o, 32'h0);
            end
            if (k == 2) begin
                // A second request while busy must not recapture the criteria.
                flush_asid_i = 9'd0; flush_vaddr_i = 32'h0; flush_req_i = 1'b1;
            end
            check($sformatf("flush_busy_c%0d", k), flush_busy_o, 1'b1);
            check($sformatf("flush_done_c%0d", k), flush_done_o, (k == 9));
            @(posedge clk_i); #1;
            flush_req_i = 1'b0;
        end
        check("flush_idle_busy", flush_busy_o, 1'b0);
        check("flush_idle_done", flush_done_o, 1'b0);
        check("flush_count", valid_count_o, 4'd1);
        lookup_check("flush_global", 9'd1, 32'h0140_0000, 1'b1, 32'h5555_0001, 2'd1);
        lookup_check("flush_gone", 9'd1, 32'h0000_3000, 1'b0, 32'h0, 2'd0);
        lookup_check("race_dropped", 9'd5, 32'h0000_9000, 1'b0, 32'h0, 2'd0);

        // Reset asserted on flush cycle 3.
        refill(20'd1, 9'd2, 2'd0, 1'b0, 32'hA1);
        refill(20'd2, 9'd2, 2'd0, 1'b0, 32'hA2);
        refill(20'd3, 9'd2, 2'd0, 1'b0, 32'hA3);
        @(posedge clk_i); #1;
        check("pre_rst_count", valid_count_o, 4'd4);
        start_flush(9'd0, 32'h0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", flush_busy_o, 1'b0);
        check("midrst_done", flush_done_o, 1'b0);
        check("midrst_count", valid_count_o, 4'd0);
        check("midrst_ready", upd_ready_o, 1'b1);
        lookup_check("midrst_global", 9'd1, 32'h0140_0000, 1'b0, 32'h0, 2'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_i); #1;
            if (flush_done_o || flush_busy_o) seen_done = 1'b1;
        end
        check("midrst_no_done", seen_done, 1'b0);
        lookup_check("midrst_entry", 9'd2, 32'h0000_2000, 1'b0, 32'h0, 2'd0);

        // Address-only flush, then address+asid flush.
        refill(20'd4, 9'd2, 2'd0, 1'b0, 32'hB4);
        refill(20'd4, 9'd3, 2'd0, 1'b0, 32'hC4);
        refill(20'd5, 9'd2, 2'd0, 1'b0, 32'hB5);
        start_flush(9'd0, 32'h0000_4000);
        wait_done("va_flush_done", 12);
        @(posedge clk_i); #1;
        check("va_flush_count", valid_count_o, 4'd1);
        lookup_check("va_flush_a2", 9'd2, 32'h0000_4000, 1'b0, 32'h0, 2'd0);
        lookup_check("va_flush_a3", 9'd3, 32'h0000_4000, 1'b0, 32'h0, 2'd0);
        lookup_check("va_flush_keep", 9'd2, 32'h0000_5000, 1'b1, 32'hB5, 2'd0);
        start_flush(9'd2, 32'h0000_5000);
        wait_done("both_flush_done", 12);
        @(posedge clk_i); #1;
        check("both_flush_count", valid_count_o, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
